// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing gated by clock-wizard lock.
// Holds idle until the synchronized lock is seen, waits a settle interval,
// then free-runs the h/v counters. Losing lock drops straight back to idle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter logic        SYNC_POL      = 1'b0,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Locked,
  output logic       Hsync,
  output logic       Vsync,
  output logic       De,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       Frame_start,
  output logic       Running
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned SCW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [9:0]     H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]     V_LAST      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t         state, state_n;
  logic [9:0]     h, h_n, v, v_n;
  logic [SCW-1:0] cnt, cnt_n;
  logic           locked_m, locked_s;

  logic           hs_n, vs_n, de_n, fs_n, run_n;
  logic [9:0]     x_n, y_n;

  // Two-flop synchronizer for the asynchronous lock status
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= Locked;
      locked_s <= locked_m;
    end
  end

  // State, settle counter and raster counters
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      h     <= h_n;
      v     <= v_n;
    end
  end

  // Next-state logic; lock loss has priority over counting
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    h_n     = h;
    v_n     = v;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_n = RUN;
          h_n     = '0;
          v_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (h == H_LAST) begin
          h_n = '0;
          v_n = (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h_n = h + 1'b1;
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  // Decode from the next-cycle position so registered outputs stay aligned with X/Y
  always_comb begin
    run_n = (state_n == RUN);
    x_n   = '0;
    y_n   = '0;
    de_n  = 1'b0;
    fs_n  = 1'b0;
    hs_n  = ~SYNC_POL;
    vs_n  = ~SYNC_POL;
    if (run_n) begin
      x_n  = h_n;
      y_n  = v_n;
      de_n = (h_n < 10'(H_ACTIVE)) && (v_n < 10'(V_ACTIVE));
      fs_n = (h_n == '0) && (v_n == '0);
      if ((h_n >= 10'(H_SYNC_START)) && (h_n < 10'(H_SYNC_END))) hs_n = SYNC_POL;
      if ((v_n >= 10'(V_SYNC_START)) && (v_n < 10'(V_SYNC_END))) vs_n = SYNC_POL;
    end
  end

  // Output registers, idle values on reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hsync       <= ~SYNC_POL;
      Vsync       <= ~SYNC_POL;
      De          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      Frame_start <= 1'b0;
      Running     <= 1'b0;
    end else begin
      Hsync       <= hs_n;
      Vsync       <= vs_n;
      De          <= de_n;
      X           <= x_n;
      Y           <= y_n;
      Frame_start <= fs_n;
      Running     <= run_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Instance A uses the default 640x480 geometry; instance B is a small
// active-high-sync geometry so full frames and wraps fit in a short run.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned edge_n;
    logic [24:0] exp;
    string       tag;
  } item_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Locked;

  logic       hs_a, vs_a, de_a, fs_a, run_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, fs_b, run_b;
  logic [9:0] x_b, y_b;

  logic [24:0] obs_a, obs_b;
  assign obs_a = {run_a, fs_a, de_a, hs_a, vs_a, x_a, y_a};
  assign obs_b = {run_b, fs_b, de_b, hs_b, vs_b, x_b, y_b};

  int unsigned edge_cnt = 0;
  int unsigned total    = 0;
  int unsigned bad      = 0;
  int unsigned n0, sa, sb, ed, er, nr;

  item_t sb_a[$];
  item_t sb_b[$];
  item_t it_a, it_b;

  vga_timing_gen dut_a (
    .Clk(Clk), .Reset(Reset), .Locked(Locked),
    .Hsync(hs_a), .Vsync(vs_a), .De(de_a), .X(x_a), .Y(y_a),
    .Frame_start(fs_a), .Running(run_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .SETTLE_CYCLES(3)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .Locked(Locked),
    .Hsync(hs_b), .Vsync(vs_b), .De(de_b), .X(x_b), .Y(y_b),
    .Frame_start(fs_b), .Running(run_b)
  );

  always #20 Clk = ~Clk;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ht(input int inst);
    return (inst == 0) ? 800 : 25;
  endfunction

  function automatic int unsigned vt(input int inst);
    return (inst == 0) ? 525 : 19;
  endfunction

  function automatic logic [24:0] idle_vec(input int inst);
    logic pol;
    pol = (inst == 0) ? 1'b0 : 1'b1;
    return {1'b0, 1'b0, 1'b0, ~pol, ~pol, 10'd0, 10'd0};
  endfunction

  function automatic logic [24:0] run_vec(input int inst, input int unsigned h, input int unsigned v);
    logic de, hs, vs, fs;
    if (inst == 0) begin
      de = (h < 640) && (v < 480);
      hs = !((h >= 656) && (h <= 751));
      vs = !((v == 490) || (v == 491));
    end else begin
      de = (h < 16) && (v < 12);
      hs = (h >= 18) && (h <= 21);
      vs = (v == 14) || (v == 15);
    end
    fs = (h == 0) && (v == 0);
    return {1'b1, fs, de, hs, vs, 10'(h), 10'(v)};
  endfunction

  task automatic push(input int inst, input int unsigned e, input logic [24:0] x, input string tag);
    item_t it;
    it.edge_n = e;
    it.exp    = x;
    it.tag    = tag;
    if (inst == 0) sb_a.push_back(it);
    else           sb_b.push_back(it);
  endtask

  task automatic push_idle(input int inst, input int unsigned e0, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++)
      push(inst, e0 + i, idle_vec(inst), $sformatf("%s e=%0d", tag, e0 + i));
  endtask

  // Expected running outputs from edge e0 for n edges, for a raster that showed (0,0) at edge start
  task automatic push_from(input int inst, input int unsigned e0, input int unsigned start,
                           input int unsigned n, input string tag);
    int unsigned t, h, v;
    t = e0 - start;
    h = t % ht(inst);
    v = (t / ht(inst)) % vt(inst);
    for (int unsigned i = 0; i < n; i++) begin
      push(inst, e0 + i, run_vec(inst, h, v), $sformatf("%s h=%0d v=%0d", tag, h, v));
      h++;
      if (h == ht(inst)) begin
        h = 0;
        v++;
        if (v == vt(inst)) v = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0) break;
      @(negedge Clk);
    end
    chk("drain_a", 25'(sb_a.size()), 25'd0);
    chk("drain_b", 25'(sb_b.size()), 25'd0);
  endtask

  // Compare due scoreboard entries for instance A
  always @(negedge Clk) begin
    while (sb_a.size() > 0 && sb_a[0].edge_n <= edge_cnt) begin
      it_a = sb_a.pop_front();
      chk({"A ", it_a.tag}, obs_a, it_a.exp);
    end
  end

  // Compare due scoreboard entries for instance B
  always @(negedge Clk) begin
    while (sb_b.size() > 0 && sb_b[0].edge_n <= edge_cnt) begin
      it_b = sb_b.pop_front();
      chk({"B ", it_b.tag}, obs_b, it_b.exp);
    end
  end

  initial begin
    Reset  = 1'b0;
    Locked = 1'b1;
    repeat (3) @(negedge Clk);
    chk("A_reset", obs_a, idle_vec(0));
    chk("B_reset", obs_b, idle_vec(1));

    // Lock-up after reset release: A runs at edge 19, B (settle 3) at edge 6
    n0 = edge_cnt;
    sa = n0 + 19;
    sb = n0 + 6;
    push_idle(0, n0 + 1, 18, "lockup_idle");
    push_from(0, sa, sa, 820, "line");
    push_idle(1, n0 + 1, 5, "lockup_idle");
    push_from(1, sb, sb, 960, "frame");
    Reset = 1'b1;
    drain();

    // Drop lock while A shows h=300
    for (int i = 0; i < 800; i++) begin
      if ((edge_cnt - sa) % 800 == 300) break;
      @(negedge Clk);
    end
    ed = edge_cnt;
    Locked = 1'b0;
    push_from(0, ed + 1, sa, 2, "drop_run");
    push_idle(0, ed + 3, 12, "drop_idle");
    push_from(1, ed + 1, sb, 2, "drop_run");
    push_idle(1, ed + 3, 12, "drop_idle");
    repeat (12) @(negedge Clk);

    // Relock restarts from (0,0) after the full settle sequence
    er = edge_cnt;
    Locked = 1'b1;
    push_idle(0, er + 3, 16, "relock_idle");
    push_from(0, er + 19, er + 19, 30, "relock");
    push_idle(1, er + 3, 3, "relock_idle");
    push_from(1, er + 6, er + 6, 30, "relock");
    drain();

    // Asynchronous reset pulse between edges
    @(negedge Clk);
    #5 Reset = 1'b0;
    #1;
    chk("A_async_reset", obs_a, idle_vec(0));
    chk("B_async_reset", obs_b, idle_vec(1));
    repeat (2) @(negedge Clk);
    chk("A_reset_held", obs_a, idle_vec(0));
    chk("B_reset_held", obs_b, idle_vec(1));

    nr = edge_cnt;
    push_idle(0, nr + 1, 18, "rst_idle");
    push_from(0, nr + 19, nr + 19, 30, "rst_restart");
    push_idle(1, nr + 1, 5, "rst_idle");
    push_from(1, nr + 6, nr + 6, 30, "rst_restart");
    Reset = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
